mem_line_arbiter: RTL and testbench
===================================

// Module: mem_line_arbiter
// PURPOSE
//  Shares the single main-memory word port between I-cache and D-cache line refills/writebacks.
//  Grants one requester at a time, then sequences a full LINE_WORDS burst.
//  Returns read words tagged with their in-line index, then pulses done.
//  Sits between the IC/DC miss logic and the memory model.
// PARAMETERS
//  LINE_WORDS  8   words per cache line (power of 2); line = LINE_WORDS*4 bytes, base aligned
//  IDX_W       3   log2(LINE_WORDS); width of beat index
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  ic_req     in   1       IC line request; held until ic_done
//  ic_addr    in   32      IC miss address (low offset bits ignored)
//  dc_req     in   1       DC line request; held until dc_done
//  dc_we      in   1       1 = DC writeback burst, 0 = DC refill
//  dc_addr    in   32      DC line address (low offset bits ignored)
//  dc_wdata   in   32      writeback word for index beat_idx (combinational from DC)
//  ic_grant   out  1       IC owns memory port
//  dc_grant   out  1       DC owns memory port
//  beat_idx   out  IDX_W   word index currently issued to memory
//  rsp_valid  out  1       rsp_data valid for the granted requester (reads only)
//  rsp_idx    out  IDX_W   word index of rsp_data
//  rsp_data   out  32      returned read word
//  ic_done    out  1       one-cycle pulse: IC burst complete
//  dc_done    out  1       one-cycle pulse: DC burst complete
//  mem_addr   out  32      word address to memory
//  mem_re     out  1       read strobe; mem_rdata valid exactly 1 cycle later
//  mem_we     out  1       write strobe; mem_wdata written same edge
//  mem_wdata  out  32      write word
//  mem_rdata  in   32      read data from memory
// BEHAVIOUR
//  Reset: every output 0; state IDLE; beat 0; last_grant = DC (IC wins first tie).
//  All outputs registered. FSM IDLE -> BURST -> DRAIN -> DONE -> IDLE.
//  IDLE: if ic_req|dc_req, pick winner: sole requester, else the one != last_grant.
//   Latch base = addr & ~(LINE_WORDS*4-1), we = dc_we (IC always read); assert grant; go BURST.
//  BURST: one beat per cycle; mem_addr = base + beat*4; mem_re = ~we; mem_we = we;
//   mem_wdata = dc_wdata; beat_idx = beat. At beat == LINE_WORDS-1 -> DRAIN; beat wraps to 0.
//  Read return: rsp_valid/rsp_idx = mem_re/beat_idx delayed 1 cycle; rsp_data = mem_rdata.
//   Last word returns in DRAIN. Writes: rsp_valid stays 0.
//  DRAIN: no strobes; DONE: grant dropped, owner's done = 1 for one cycle, last_grant <= owner.
//  Latency (read, req sampled cycle 0): grant+beat0 cycle 1, rsp beats cycles 2..9,
//   done cycle 10, IDLE cycle 11, next grant earliest cycle 12.
//  Request dropped mid-burst: ignored, burst completes and done still pulses.
//  Request of owner still high in IDLE after done: treated as new request (arbitrated fairly).
//  Both requests high continuously: strict alternation IC, DC, IC, ...
//  Requests arriving during BURST/DRAIN/DONE: wait; never preempt.
//  Reset mid-burst: immediate abandon, all strobes/grants/done 0 in same cycle reset asserts.
//  grant is one-hot or zero; mem_re & mem_we never both 1.
// STRUCTURE
//  config.v: `define LINE_WORDS, `define IDX_W, FSM encodings S_IDLE/S_BURST/S_DRAIN/S_DONE.
//  Sub-module rr_arb2: 2-input round-robin picker (req[1:0], last -> gnt one-hot).
//  Top holds FSM, beat counter, base/we latches, response delay stage.
// TESTING
//  1 Reset then ic_req, ic_addr=0x0000_1234 -> cycle1 ic_grant, mem_addr 0x1220..0x123C
//    on mem_re; rsp_idx 0..7 cycles 2..9; ic_done cycle 10 only.
//  2 dc_req, dc_we=1, dc_addr=0x0000_8040, dc_wdata=0xA0+beat_idx -> mem_we 8 beats,
//    mem_wdata 0xA0..0xA7 at 0x8040..0x805C; rsp_valid never 1; dc_done once.
//  3 ic_req & dc_req same cycle, both held -> IC, DC, IC grants in order; no overlap;
//    grant gap exactly 1 idle cycle after each done.
//  4 dc_req rises during IC burst -> DC granted only after ic_done; IC data unaffected.
//  5 reset asserted at beat 4 -> outputs 0 immediately; after release, ic_req ->
//    fresh burst starting beat 0.
//  6 ic_req dropped at beat 2 -> burst still issues 8 beats and pulses ic_done.

Source files
------------

// File: rtl/mem_line_arbiter_pkg.sv
// mem_line_arbiter_pkg: line geometry, burst FSM states and address helpers
package mem_line_arbiter_pkg;
    localparam int LINE_WORDS = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_DONE} state_t;

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a & ~32'(LINE_WORDS * 4 - 1);
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
        return base | {{(30 - IDX_W){1'b0}}, idx, 2'b00};
    endfunction
endpackage

// File: rtl/mem_line_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the side that did not win last time wins
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb gnt = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares the memory word port between I-cache and D-cache line bursts
module mem_line_arbiter
    import mem_line_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ic_req,
    input  logic [31:0]      ic_addr,
    input  logic             dc_req,
    input  logic             dc_we,
    input  logic [31:0]      dc_addr,
    input  logic [31:0]      dc_wdata,
    output logic             ic_grant,
    output logic             dc_grant,
    output logic [IDX_W-1:0] beat_idx,
    output logic             rsp_valid,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [31:0]      rsp_data,
    output logic             ic_done,
    output logic             dc_done,
    output logic [31:0]      mem_addr,
    output logic             mem_re,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);
    state_t state;
    logic owner;
    logic last_grant;
    logic [1:0] gnt;
    logic [31:0] base;
    logic [31:0] win_base;
    logic win_we;
    logic [IDX_W-1:0] nxt;

    rr_arb2 u_arb (
        .req  ({dc_req, ic_req}),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign win_base = line_base(gnt[1] ? dc_addr : ic_addr);
    assign win_we = gnt[1] & dc_we;
    assign nxt = beat_idx + 1'b1;
    // DC drives its word combinationally from beat_idx, so data pairs with the registered address
    assign mem_wdata = mem_we ? dc_wdata : '0;
    // memory returns data one cycle after the strobe, aligned with the delayed rsp_valid
    assign rsp_data = rsp_valid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            owner <= 1'b0;
            last_grant <= 1'b1;
            base <= '0;
            ic_grant <= 1'b0;
            dc_grant <= 1'b0;
            beat_idx <= '0;
            rsp_valid <= 1'b0;
            rsp_idx <= '0;
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            mem_addr <= '0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
        end else begin
            rsp_valid <= mem_re;
            rsp_idx <= beat_idx;
            case (state)
                S_IDLE: if (|gnt) begin
                    state <= S_BURST;
                    owner <= gnt[1];
                    base <= win_base;
                    ic_grant <= gnt[0];
                    dc_grant <= gnt[1];
                    beat_idx <= '0;
                    mem_addr <= win_base;
                    mem_re <= ~win_we;
                    mem_we <= win_we;
                end
                S_BURST: if (&beat_idx) begin
                    state <= S_DRAIN;
                    beat_idx <= '0;
                    mem_addr <= '0;
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                end else begin
                    beat_idx <= nxt;
                    mem_addr <= word_addr(base, nxt);
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    ic_grant <= 1'b0;
                    dc_grant <= 1'b0;
                    ic_done <= ~owner;
                    dc_done <= owner;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ic_done <= 1'b0;
                    dc_done <= 1'b0;
                    last_grant <= owner;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: directed vectors and burst sequences against hand-computed expectations
module tb_mem_line_arbiter;
    localparam logic [31:0] M = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
    logic [31:0] ic_addr = '0, dc_addr = '0, dc_wdata;
    logic ic_grant, dc_grant, rsp_valid, ic_done, dc_done, mem_re, mem_we;
    logic [2:0] beat_idx, rsp_idx;
    logic [31:0] rsp_data, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0, nxt_rdata = '0;

    int checks = 0, errors = 0;
    int cyc = 0, re_n = 0, icd_n = 0, dcd_n = 0, viol = 0;
    logic p_ic = 1'b0, p_dc = 1'b0, p_icd = 1'b0, p_dcd = 1'b0;
    int g_who[$], g_cyc[$], d_cyc[$];
    logic [34:0] r_q[$];
    logic [63:0] w_q[$];

    typedef struct {
        logic req;
        logic g;
        logic re;
        logic [31:0] addr;
        logic rv;
        logic [2:0] ridx;
        logic [31:0] rdat;
        logic done;
    } vec_t;
    vec_t tv[12];

    mem_line_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .ic_grant(ic_grant), .dc_grant(dc_grant), .beat_idx(beat_idx),
        .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
        .ic_done(ic_done), .dc_done(dc_done),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign dc_wdata = 32'hA0 + 32'(beat_idx);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= nxt_rdata;
    end

    always @(negedge clk) begin
        if (ic_grant && !p_ic) begin g_who.push_back(0); g_cyc.push_back(cyc); end
        if (dc_grant && !p_dc) begin g_who.push_back(1); g_cyc.push_back(cyc); end
        if (ic_done || dc_done) d_cyc.push_back(cyc);
        if (rsp_valid) r_q.push_back({rsp_idx, rsp_data});
        if (mem_we) w_q.push_back({mem_addr, mem_wdata});
        re_n <= re_n + int'(mem_re);
        icd_n <= icd_n + int'(ic_done);
        dcd_n <= dcd_n + int'(dc_done);
        if ((ic_grant && dc_grant) || (mem_re && mem_we) || (ic_done && p_icd) || (dc_done && p_dcd))
            viol <= viol + 1;
        p_ic <= ic_grant;
        p_dc <= dc_grant;
        p_icd <= ic_done;
        p_dcd <= dc_done;
        nxt_rdata <= mem_re ? mem_addr ^ M : 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input bit dc, input string nm);
        int n = 0;
        while (!(dc ? dc_done : ic_done) && n < 40) begin @(negedge clk); n++; end
        chk(nm, 64'(dc ? dc_done : ic_done), 64'd1);
    endtask

    task automatic wait_beat(input logic [2:0] k, input string nm);
        int n = 0;
        while (!(ic_grant && mem_re && beat_idx == k) && n < 40) begin @(negedge clk); n++; end
        chk(nm, 64'(ic_grant && mem_re && beat_idx == k), 64'd1);
    endtask

    task automatic wait_ic_grant(input string nm);
        int n = 0;
        while (!ic_grant && n < 40) begin @(negedge clk); n++; end
        chk(nm, 64'(ic_grant), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g0, d0, r0, w0, re0, n0;
        for (int c = 0; c < 12; c++) begin
            tv[c].req = (c < 10);
            tv[c].g = (c >= 1 && c <= 9);
            tv[c].re = (c >= 1 && c <= 8);
            tv[c].addr = 32'h1220 + 32'(4 * (c - 1));
            tv[c].rv = (c >= 2 && c <= 9);
            tv[c].ridx = 3'(c - 2);
            tv[c].rdat = (32'h1220 + 32'(4 * (c - 2))) ^ M;
            tv[c].done = (c == 10);
        end

        // reset state
        idle(3);
        chk("rst_strobes", {ic_grant, dc_grant, mem_re, mem_we, rsp_valid, ic_done, dc_done}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_idx", {beat_idx, rsp_idx}, 0);
        chk("rst_data", {rsp_data, mem_wdata}, 0);
        reset = 1'b1;

        // 1: IC refill, cycle-by-cycle
        ic_addr = 32'h0000_1234;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            ic_req = tv[c].req;
            @(negedge clk);
            chk($sformatf("t1_grant_c%0d", c), {ic_grant, dc_grant}, {tv[c].g, 1'b0});
            chk($sformatf("t1_strobe_c%0d", c), {mem_re, mem_we}, {tv[c].re, 1'b0});
            if (tv[c].re) chk($sformatf("t1_addr_c%0d", c), {beat_idx, mem_addr}, {3'(c - 1), tv[c].addr});
            chk($sformatf("t1_rv_c%0d", c), rsp_valid, tv[c].rv);
            if (tv[c].rv) chk($sformatf("t1_rsp_c%0d", c), {rsp_idx, rsp_data}, {tv[c].ridx, tv[c].rdat});
            chk($sformatf("t1_done_c%0d", c), {ic_done, dc_done}, {tv[c].done, 1'b0});
        end

        // 2: DC writeback
        w0 = w_q.size(); r0 = r_q.size(); n0 = dcd_n; g0 = g_who.size();
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_8047;
        wait_done(1'b1, "t2_dc_done");
        dc_req = 1'b0;
        idle(3);
        chk("t2_nwrites", w_q.size() - w0, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_write%0d", i), w_q[w0 + i], {32'h8040 + 32'(4 * i), 32'hA0 + 32'(i)});
        chk("t2_no_rsp", r_q.size() - r0, 0);
        chk("t2_done_once", dcd_n - n0, 1);
        chk("t2_dc_granted", {g_who.size() - g0, g_who[g0]}, {32'd1, 32'd1});

        // 3: simultaneous held requests alternate IC, DC, IC
        g0 = g_who.size(); d0 = d_cyc.size();
        dc_we = 1'b0; ic_addr = 32'h100; dc_addr = 32'h200;
        ic_req = 1'b1; dc_req = 1'b1;
        wait_done(1'b0, "t3_ic_done1");
        @(negedge clk);
        wait_done(1'b1, "t3_dc_done");
        @(negedge clk);
        wait_done(1'b0, "t3_ic_done2");
        ic_req = 1'b0; dc_req = 1'b0;
        idle(3);
        chk("t3_ngrants", g_who.size() - g0, 3);
        chk("t3_order", {g_who[g0], g_who[g0 + 1], g_who[g0 + 2]}, {32'd0, 32'd1, 32'd0});
        chk("t3_gap1", g_cyc[g0 + 1] - d_cyc[d0], 2);
        chk("t3_gap2", g_cyc[g0 + 2] - d_cyc[d0 + 1], 2);

        // 4: DC request arrives mid IC burst
        g0 = g_who.size(); d0 = d_cyc.size(); r0 = r_q.size();
        ic_addr = 32'h0000_2010; dc_addr = 32'h0000_3000;
        ic_req = 1'b1;
        idle(3);
        dc_req = 1'b1;
        wait_done(1'b0, "t4_ic_done");
        ic_req = 1'b0;
        @(negedge clk);
        wait_done(1'b1, "t4_dc_done");
        dc_req = 1'b0;
        idle(3);
        chk("t4_order", {g_who[g0], g_who[g0 + 1]}, {32'd0, 32'd1});
        chk("t4_gap", g_cyc[g0 + 1] - d_cyc[d0], 2);
        chk("t4_nrsp", r_q.size() - r0, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t4_rsp%0d", i), r_q[r0 + i],
                {3'(i), ((i < 8 ? 32'h2000 : 32'h3000) + 32'(4 * (i % 8))) ^ M});

        // 5: reset at beat 4, then a fresh burst
        ic_addr = 32'h0000_4000;
        ic_req = 1'b1;
        wait_beat(3'd4, "t5_reach_beat4");
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_strobes", {ic_grant, dc_grant, mem_re, mem_we, rsp_valid, ic_done, dc_done}, 0);
        chk("t5_rst_addr", {beat_idx, mem_addr}, 0);
        ic_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        r0 = r_q.size();
        ic_addr = 32'h0000_5004;
        ic_req = 1'b1;
        wait_ic_grant("t5_regrant");
        chk("t5_fresh_beat0", {beat_idx, mem_addr}, {3'd0, 32'h5000});
        wait_done(1'b0, "t5_ic_done");
        ic_req = 1'b0;
        idle(3);
        chk("t5_nrsp", r_q.size() - r0, 8);
        chk("t5_rsp7", r_q[r0 + 7], {3'd7, 32'h501C ^ M});

        // 6: IC request dropped at beat 2
        re0 = re_n; n0 = icd_n;
        ic_addr = 32'h0000_6000;
        ic_req = 1'b1;
        wait_beat(3'd2, "t6_reach_beat2");
        ic_req = 1'b0;
        wait_done(1'b0, "t6_ic_done");
        idle(3);
        chk("t6_nbeats", re_n - re0, 8);
        chk("t6_done_once", icd_n - n0, 1);

        chk("invariants", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
